bhg_psg_mixer: RTL and testbench



---
 rtl/bhg_psg_pkg.sv | 23 ++
 rtl/bhg_psg_exp_lut.sv | 30 +++
 rtl/bhg_psg_mixer.sv | 120 ++++++++++++
 tb/tb_bhg_psg_mixer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bhg_psg_pkg.sv
// Shared constants and the YM2149-style log-to-linear amplitude law for the PSG mixer.
package bhg_psg_pkg;

  localparam int LOG_W   = 5;
  localparam int NCH_MIN = 1;
  localparam int NCH_MAX = 8;
  localparam int DAC_MIN = 8;
  localparam int DAC_MAX = 14;

  // One log step in dB, and the matching amplitude ratio 10^(-STEP_DB/20).
  localparam real STEP_DB   = 1.5;
  localparam real STEP_GAIN = 0.8413951416451951;

  // Linear amplitude for log level n at full scale (2^dac_bits - 1); level 0 is silent.
  function automatic int lin_code(input int n, input int dac_bits);
    real amp;
    if (n <= 0) return 0;
    amp = real'((1 << dac_bits) - 1);
    for (int i = n; i < (1 << LOG_W) - 1; i++) amp = amp * STEP_GAIN;
    return int'(amp);
  endfunction

endpackage

// File: rtl/bhg_psg_exp_lut.sv
// 32-entry log-to-linear ROM, contents fixed at elaboration, with a registered output.
module bhg_psg_exp_lut
  import bhg_psg_pkg::*;
#(
  parameter int DAC_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LOG_W-1:0]    addr_d_i,
  output logic [DAC_BITS-1:0] lin_o
);

  logic [DAC_BITS-1:0] rom [1 << LOG_W];
  logic [DAC_BITS-1:0] lin_q;

  for (genvar i = 0; i < (1 << LOG_W); i++) begin : g_rom
    assign rom[i] = DAC_BITS'(lin_code(i, DAC_BITS));
  end

  // Indexed by the address register's next state, so lin_o always matches the
  // address register one clk after it is loaded, whatever clk_en does.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) lin_q <= '0;
    else     lin_q <= rom[addr_d_i];
  end

  assign lin_o = lin_q;

endmodule

// File: rtl/bhg_psg_mixer.sv
// Time-multiplexed N-channel PSG output stage: shared log->lin lookup, stereo panned sums.
module bhg_psg_mixer
  import bhg_psg_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int DAC_BITS = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clk_en,
  input  logic [LOG_W*NCH-1:0]               level,
  input  logic [NCH-1:0]                     pan_l,
  input  logic [NCH-1:0]                     pan_r,
  output logic [DAC_BITS*NCH-1:0]            ch_lin,
  output logic [DAC_BITS+$clog2(NCH)-1:0]    left,
  output logic [DAC_BITS+$clog2(NCH)-1:0]    right,
  output logic                               sample
);

  localparam int SUM_W  = DAC_BITS + $clog2(NCH);
  localparam int SLOT_W = $clog2(NCH + 2);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NCH + 1);

  if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
    $error("bhg_psg_mixer: NCH out of range 1..8");
  end
  if (DAC_BITS < DAC_MIN || DAC_BITS > DAC_MAX) begin : g_bad_dac
    $error("bhg_psg_mixer: DAC_BITS out of range 8..14");
  end

  logic [SLOT_W-1:0]         slot_q, slot_d;
  logic [SUM_W-1:0]          acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [SUM_W-1:0]          left_q, left_d, right_q, right_d;
  logic [LOG_W*NCH-1:0]      snap_lv_q, snap_lv_d;
  logic [NCH-1:0]            snap_pl_q, snap_pl_d, snap_pr_q, snap_pr_d;
  logic [LOG_W-1:0]          addr_q, addr_d;
  logic [DAC_BITS*NCH-1:0]   ch_lin_q, ch_lin_d;
  logic                      sample_q, sample_d;
  logic [DAC_BITS-1:0]       lin;

  bhg_psg_exp_lut #(.DAC_BITS(DAC_BITS)) u_lut (
    .clk      (clk),
    .rst      (rst),
    .addr_d_i (addr_d),
    .lin_o    (lin)
  );

  // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    slot_d    = slot_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    left_d    = left_q;
    right_d   = right_q;
    snap_lv_d = snap_lv_q;
    snap_pl_d = snap_pl_q;
    snap_pr_d = snap_pr_q;
    addr_d    = addr_q;
    ch_lin_d  = ch_lin_q;
    sample_d  = 1'b0;

    if (clk_en) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
      if (slot_q == '0) begin
        left_d    = acc_l_q;
        right_d   = acc_r_q;
        sample_d  = 1'b1;
        acc_l_d   = '0;
        acc_r_d   = '0;
        snap_lv_d = level;
        snap_pl_d = pan_l;
        snap_pr_d = pan_r;
      end else begin
        // Channel k is addressed at slot k+1 and accumulated at slot k+2.
        for (int k = 0; k < NCH; k++) begin
          if (slot_q == SLOT_W'(k + 1)) addr_d = snap_lv_q[k*LOG_W +: LOG_W];
          if (slot_q == SLOT_W'(k + 2)) begin
            ch_lin_d[k*DAC_BITS +: DAC_BITS] = lin;
            if (snap_pl_q[k]) acc_l_d = acc_l_q + SUM_W'(lin);
            if (snap_pr_q[k]) acc_r_d = acc_r_q + SUM_W'(lin);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q    <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      left_q    <= '0;
      right_q   <= '0;
      snap_lv_q <= '0;
      snap_pl_q <= '0;
      snap_pr_q <= '0;
      addr_q    <= '0;
      ch_lin_q  <= '0;
      sample_q  <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      left_q    <= left_d;
      right_q   <= right_d;
      snap_lv_q <= snap_lv_d;
      snap_pl_q <= snap_pl_d;
      snap_pr_q <= snap_pr_d;
      addr_q    <= addr_d;
      ch_lin_q  <= ch_lin_d;
      sample_q  <= sample_d;
    end
  end

  assign ch_lin = ch_lin_q;
  assign left   = left_q;
  assign right  = right_q;
  assign sample = sample_q;

endmodule

// File: tb/tb_bhg_psg_mixer.sv
// Self-checking bench: table vectors on a 4-channel/10-bit instance, directed and random
// frames on a 3-channel/8-bit instance checked against a frame-level reference model.
module tb_bhg_psg_mixer;

  localparam int NA = 3, DA = 8,  SA = DA + 2;
  localparam int NB = 4, DB = 10, SB = DB + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              en_a = 1'b1;
  logic [5*NA-1:0]   level_a = '0;
  logic [NA-1:0]     pl_a = '0, pr_a = '0;
  logic [DA*NA-1:0]  ch_a;
  logic [SA-1:0]     left_a, right_a;
  logic              sample_a;

  logic              en_b = 1'b1;
  logic [5*NB-1:0]   level_b = '0;
  logic [NB-1:0]     pl_b = '0, pr_b = '0;
  logic [DB*NB-1:0]  ch_b;
  logic [SB-1:0]     left_b, right_b;
  logic              sample_b;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  bhg_psg_mixer #(.NCH(NA), .DAC_BITS(DA)) dut_a (
    .clk(clk), .rst(rst), .clk_en(en_a), .level(level_a), .pan_l(pl_a), .pan_r(pr_a),
    .ch_lin(ch_a), .left(left_a), .right(right_a), .sample(sample_a)
  );

  bhg_psg_mixer #(.NCH(NB), .DAC_BITS(DB)) dut_b (
    .clk(clk), .rst(rst), .clk_en(en_b), .level(level_b), .pan_l(pl_b), .pan_r(pr_b),
    .ch_lin(ch_b), .left(left_b), .right(right_b), .sample(sample_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Amplitude law straight from the dB definition.
  function automatic int lin_ref(input int n, input int bits);
    real db;
    if (n == 0) return 0;
    db = -1.5 * real'(31 - n);
    return int'($floor(real'((1 << bits) - 1) * (10.0 ** (db / 20.0)) + 0.5));
  endfunction

  // Frame-level model of instance A: every (NCH+2)th enabled cycle after reset publishes
  // the sums of the inputs captured at the previous publish.
  int en_cnt = 0;
  bit have_snap = 0, chk_ch = 0, exp_s = 0;
  int snap_lv[NA];
  bit snap_pl[NA], snap_pr[NA];
  int exp_l = 0, exp_r = 0;
  int exp_ch[NA];

  always @(posedge clk) begin
    chk_ch = 0;
    if (rst) begin
      en_cnt = 0; have_snap = 0; exp_s = 0; exp_l = 0; exp_r = 0; chk_ch = 1;
      for (int k = 0; k < NA; k++) exp_ch[k] = 0;
    end else if (en_a) begin
      exp_s = (en_cnt % (NA + 2) == 0);
      if (exp_s) begin
        chk_ch = 1; exp_l = 0; exp_r = 0;
        for (int k = 0; k < NA; k++) begin
          exp_ch[k] = have_snap ? lin_ref(snap_lv[k], DA) : 0;
          if (have_snap && snap_pl[k]) exp_l += exp_ch[k];
          if (have_snap && snap_pr[k]) exp_r += exp_ch[k];
        end
        for (int k = 0; k < NA; k++) begin
          snap_lv[k] = int'(level_a[5*k +: 5]);
          snap_pl[k] = pl_a[k];
          snap_pr[k] = pr_a[k];
        end
        have_snap = 1;
      end
      en_cnt++;
    end else begin
      exp_s = 0;
    end
  end

  always @(negedge clk) begin
    check("a_sample", sample_a, exp_s);
    check("a_left", left_a, exp_l);
    check("a_right", right_a, exp_r);
    if (chk_ch)
      for (int k = 0; k < NA; k++) check("a_ch_lin", ch_a[DA*k +: DA], exp_ch[k]);
  end

  task automatic wait_sample(input bit use_b, output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (use_b ? sample_b : sample_a) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_err++;
      $display("FAIL sample_timeout: got no strobe within 100 clk, expected one");
    end
  endtask

  typedef struct {
    logic [5*NB-1:0]  lv;
    logic [NB-1:0]    pl;
    logic [NB-1:0]    pr;
    int               el;
    int               er;
    logic [DB*NB-1:0] ech;
  } vec_t;

  vec_t vecs[5];
  int   sweep_lv[4]  = '{31, 30, 1, 0};
  int   sweep_exp[4] = '{255, 215, 1, 0};

  initial begin
    bit ok;
    int cnt, npub;

    vecs[0] = '{{5'd31, 5'd0, 5'd31, 5'd31}, 4'b0011, 4'b1100, 2046, 1023,
                {10'd1023, 10'd0, 10'd1023, 10'd1023}};
    vecs[1] = '{{4{5'd31}}, 4'b1111, 4'b1111, 4092, 4092, {4{10'd1023}}};
    vecs[2] = '{{5'd31, 5'd0, 5'd1, 5'd30}, 4'b1111, 4'b0000, 1890, 0,
                {10'd1023, 10'd0, 10'd6, 10'd861}};
    vecs[3] = '{{4{5'd31}}, 4'b0000, 4'b0000, 0, 0, {4{10'd1023}}};
    vecs[4] = '{'0, 4'b1111, 4'b1111, 0, 0, '0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_left_b", left_b, 0);
    check("rst_right_b", right_b, 0);
    check("rst_sample_b", sample_b, 0);
    check("rst_ch_lin_b", ch_b, 0);
    rst = 1'b0;

    @(posedge clk); #1;
    check("first_sample_b", sample_b, 1);
    check("first_left_b", left_b, 0);
    check("first_right_b", right_b, 0);

    for (int i = 0; i < 5; i++) begin
      level_b = vecs[i].lv; pl_b = vecs[i].pl; pr_b = vecs[i].pr;
      wait_sample(1'b1, ok);
      if (ok) wait_sample(1'b1, ok);
      if (ok) begin
        check("tbl_left_b", left_b, vecs[i].el);
        check("tbl_right_b", right_b, vecs[i].er);
        check("tbl_ch_lin_b", ch_b, vecs[i].ech);
      end
    end

    pl_a = 3'b001; pr_a = 3'b001;
    for (int i = 0; i < 4; i++) begin
      level_a = {10'd0, 5'(sweep_lv[i])};
      wait_sample(1'b0, ok);
      if (ok) wait_sample(1'b0, ok);
      if (ok) begin
        check("sweep_left_a", left_a, sweep_exp[i]);
        check("sweep_ch0_a", ch_a[DA-1:0], sweep_exp[i]);
      end
    end

    level_a = {3{5'd31}}; pl_a = 3'b111; pr_a = 3'b111;
    wait_sample(1'b0, ok);
    wait_sample(1'b0, ok);
    check("full_left_a", left_a, 765);
    check("full_right_a", right_a, 765);
    check("full_ch_lin_a", ch_a, {3{8'd255}});
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (!sample_a && cnt < 20);
    check("sample_period_a", cnt, 5);

    // Level change after slot 2 must not disturb the frame already in flight.
    @(posedge clk); @(posedge clk); #1;
    level_a = '0;
    wait_sample(1'b0, ok);
    check("midframe_old_a", left_a, 765);
    wait_sample(1'b0, ok);
    check("midframe_new_a", left_a, 0);

    level_a = {3{5'd31}};
    npub = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      en_a = (i % 3 == 2);
      if (sample_a) begin
        npub++;
        if (npub >= 2) check("gated_left_a", left_a, 765);
      end
    end
    check("gated_frames_a", npub, 3);
    en_a = 1'b1;

    wait_sample(1'b0, ok);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_left_a", left_a, 0);
    check("midrst_ch_lin_a", ch_a, 0);
    check("midrst_sample_a", sample_a, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("postrst_sample_a", sample_a, 1);
    check("postrst_left_a", left_a, 0);
    wait_sample(1'b0, ok);
    check("postrst_frame_a", left_a, 765);
    check("postrst_frame_r_a", right_a, 765);

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      en_a = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) begin
        level_a = 15'($urandom);
        pl_a    = 3'($urandom);
        pr_a    = 3'($urandom);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
